// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - op_t      : ALU opcode encodings (4 bits)
//   - state_t   : arbiter FSM states
//   - FLAG_*    : bit positions of Z/V/N inside any 3-bit ZVN vector
//   - z_write_en / vn_write_en / next_flags : flag-register write decode
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Z is architecturally meaningful for the arithmetic/logic/shift ops,
  // excluding RED/PADDSB (op[1:0]==2'b11) and everything with op[3] set.
  function automatic logic z_write_en(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[1:0] != 2'b11);
  endfunction

  // V and N are only produced by ADD and SUB.
  function automatic logic vn_write_en(input logic [3:0] op);
    return (op[3:1] == 3'b000);
  endfunction

  // Merge freshly produced ZVN into the current register, field by field.
  function automatic logic [2:0] next_flags(input logic [2:0] cur,
                                            input logic [2:0] zvn,
                                            input logic [3:0] op);
    logic [2:0] nf;
    nf = cur;
    if (z_write_en(op)) nf[FLAG_Z] = zvn[FLAG_Z];
    if (vn_write_en(op)) begin
      nf[FLAG_V] = zvn[FLAG_V];
      nf[FLAG_N] = zvn[FLAG_N];
    end
    return nf;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between the two ALU requesters
// (port 0 = EX stage, port 1 = aux/debug unit) and the arbiter.
//   reqN_valid/op/a/b : request from port N       reqN_ready : accepted
//   rspN_valid        : result ready for port N   rspN_ready : consumed
//   rsp_data/rsp_zvn  : shared registered result, qualified by rspN_valid
//
// Handshake rule (both directions): a transfer happens on a rising edge
// where valid && ready are both high. The source holds valid and its
// payload stable until that edge; ready never rises without valid.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_zvn;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_zvn
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_zvn
  );
endinterface

// File: rtl/alu_arbiter_arb.sv
// rr_arb2: two-input arbiter.
//   RR=1 : round-robin; on a tie the port not granted last wins.
//   RR=0 : fixed priority, port 0 always wins.
// Ports: clk, rst (sync, active high), req[1:0], en (arbitration allowed
// this cycle), gnt[1:0] (one-hot or zero, combinational).
// The pointer moves only when a grant is issued, i.e. on a handshake,
// since gnt is only ever raised against a valid request.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (!RR || last_grant) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Resets to 1 so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 16-bit ALU between two requesters and
// owns the architectural ZVN flag register (written by port 0 only).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : request/response handshakes, see alu_arbiter_if
//   alu_in1/alu_in2     : registered operands to the ALU
//   alu_opcode          : registered opcode to the ALU
//   alu_out/alu_zvn     : combinational ALU result and flags
//   flags               : architectural ZVN register (bit2 Z, bit1 V, bit0 N)
//   state_dbg           : current FSM state
// One op takes IDLE (grant) -> EXEC (ALU settles, result captured) ->
// RESP (held until the owner consumes it).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_zvn,
  output logic [2:0]  flags,
  output state_t      state_dbg
);

  state_t      state_q, state_d;
  logic        owner_q;       // 0 = port 0, 1 = port 1
  logic [1:0]  gnt;
  logic        req_hs;
  logic        rsp_hs;
  logic [15:0] rsp_data_q;
  logic [2:0]  rsp_zvn_q;

  rr_arb2 #(.RR(RR)) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.req1_valid, bus.req0_valid}),
    .en  (state_q == IDLE),
    .gnt (gnt)
  );

  assign req_hs = |gnt;
  assign rsp_hs = (state_q == RESP) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      alu_in1    <= 16'h0000;
      alu_in2    <= 16'h0000;
      alu_opcode <= 4'h0;
      rsp_data_q <= 16'h0000;
      rsp_zvn_q  <= 3'b000;
      flags      <= 3'b000;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        owner_q    <= gnt[1];
        alu_opcode <= gnt[1] ? bus.req1_op : bus.req0_op;
        alu_in1    <= gnt[1] ? bus.req1_a  : bus.req0_a;
        alu_in2    <= gnt[1] ? bus.req1_b  : bus.req0_b;
      end
      // The ALU inputs have been stable for the whole EXEC cycle.
      if (state_q == EXEC) begin
        rsp_data_q <= alu_out;
        rsp_zvn_q  <= alu_zvn;
        if (!owner_q) flags <= next_flags(flags, alu_zvn, alu_opcode);
      end
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zvn    = rsp_zvn_q;
  assign state_dbg      = state_q;

endmodule
